sa_controller: RTL and testbench

SA_CONTROLLER -- requirements
Module: sa_controller

---
 rtl/sa_controller.sv | 152 +++++++++++++++
 tb/tb_sa_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_controller.sv
// Control sequencer for a ROWS x COLS weight-stationary systolic array:
// weight preload, input streaming, pipeline drain and output write-back.
module sa_controller #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 16,
  parameter int M_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_weight_offset,
  input  logic [ADDR_W-1:0] cfg_input_offset,
  input  logic [ADDR_W-1:0] cfg_output_offset,
  input  logic [M_W-1:0]    cfg_m,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state,
  output logic              weight_rd_en,
  output logic [ADDR_W-1:0] weight_rd_addr,
  output logic              preload_en,
  output logic              input_rd_en,
  output logic [ADDR_W-1:0] input_rd_addr,
  output logic              stream_en,
  output logic              output_wr_en,
  output logic [ADDR_W-1:0] output_wr_addr
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_PRELOAD = 2'b01;
  localparam logic [1:0] S_STREAM  = 2'b10;
  localparam logic [1:0] S_FLUSH   = 2'b11;

  localparam int CW = M_W + 1;
  localparam int LAT = ROWS + COLS - 1;
  localparam logic [CW-1:0] LAT_C     = CW'(LAT);
  localparam logic [CW-1:0] ROWS_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [1:0]        state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              done_r, done_s;
  logic              load_cfg_s;
  logic [M_W-1:0]    m_r;
  logic [ADDR_W-1:0] w_off_r, in_off_r, out_off_r;
  logic [CW-1:0]     m_ext_s, last_stream_s, last_flush_s;

  // One counter serves as k during PRELOAD and as c during STREAM/FLUSH.
  assign m_ext_s       = {1'b0, m_r};
  assign last_stream_s = m_ext_s - ONE_C;
  assign last_flush_s  = m_ext_s + LAT_C - ONE_C;

  // Next-state, counter and done-pulse decision; abort overrides everything.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    done_s     = 1'b0;
    load_cfg_s = 1'b0;
    if (abort && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
      cnt_s   = ZERO_C;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (cfg_m != {M_W{1'b0}})) begin
            state_s    = S_PRELOAD;
            cnt_s      = ZERO_C;
            load_cfg_s = 1'b1;
          end else if (start) begin
            done_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end
        S_PRELOAD: begin
          if (cnt_r == ROWS_LAST) begin
            state_s = S_STREAM;
            cnt_s   = ZERO_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_STREAM: begin
          cnt_s = cnt_r + ONE_C;
          if (cnt_r == last_stream_s) begin
            state_s = S_FLUSH;
          end else begin
            state_s = S_STREAM;
          end
        end
        S_FLUSH: begin
          if (cnt_r == last_flush_s) begin
            state_s = S_IDLE;
            cnt_s   = ZERO_C;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = ZERO_C;
        end
      endcase
    end
  end

  // State, counter, done pulse and configuration snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= ZERO_C;
      done_r    <= 1'b0;
      m_r       <= {M_W{1'b0}};
      w_off_r   <= ADDR_ZERO;
      in_off_r  <= ADDR_ZERO;
      out_off_r <= ADDR_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
      if (load_cfg_s) begin
        m_r       <= cfg_m;
        w_off_r   <= cfg_weight_offset;
        in_off_r  <= cfg_input_offset;
        out_off_r <= cfg_output_offset;
      end else begin
        m_r       <= m_r;
        w_off_r   <= w_off_r;
        in_off_r  <= in_off_r;
        out_off_r <= out_off_r;
      end
    end
  end

  // Moore output decode; addresses read as zero whenever their enable is low.
  assign state          = state_r;
  assign busy           = (state_r != S_IDLE);
  assign done           = done_r;
  assign weight_rd_en   = (state_r == S_PRELOAD);
  assign preload_en     = (state_r == S_PRELOAD);
  assign weight_rd_addr = weight_rd_en ? (w_off_r + ADDR_W'(cnt_r)) : ADDR_ZERO;
  assign input_rd_en    = (state_r == S_STREAM);
  assign input_rd_addr  = input_rd_en ? (in_off_r + ADDR_W'(cnt_r)) : ADDR_ZERO;
  assign stream_en      = state_r[1];
  assign output_wr_en   = state_r[1] && (cnt_r >= LAT_C);
  assign output_wr_addr = output_wr_en ? (out_off_r + ADDR_W'(cnt_r - LAT_C)) : ADDR_ZERO;

endmodule

// File: tb/tb_sa_controller.sv
// Bench for sa_controller: elapsed-cycle reference model checked every cycle,
// plus directed runs with hand-computed address/timing expectations.
module tb_sa_controller;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int ADDR_W = 16;
  localparam int M_W = 16;
  localparam int LAT = ROWS + COLS - 1;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [15:0] cfg_w, cfg_i, cfg_o, cfg_m;
  logic busy, done, weight_rd_en, preload_en, input_rd_en, stream_en, output_wr_en;
  logic [1:0] state;
  logic [15:0] weight_rd_addr, input_rd_addr, output_wr_addr;

  sa_controller #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .M_W(M_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_weight_offset(cfg_w), .cfg_input_offset(cfg_i), .cfg_output_offset(cfg_o),
    .cfg_m(cfg_m), .busy(busy), .done(done), .state(state),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .preload_en(preload_en),
    .input_rd_en(input_rd_en), .input_rd_addr(input_rd_addr), .stream_en(stream_en),
    .output_wr_en(output_wr_en), .output_wr_addr(output_wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is just "j cycles since start was accepted".
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  int m_j = 0;
  int m_M = 0;
  logic [15:0] m_w = 16'h0000, m_i = 16'h0000, m_o = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_j <= 0; m_M <= 0;
      m_w <= 16'h0000; m_i <= 16'h0000; m_o <= 16'h0000;
    end else begin
      m_done <= 1'b0;
      if (m_run) begin
        if (abort) m_run <= 1'b0;
        else if (m_j == ROWS + m_M + LAT - 1) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end else m_j <= m_j + 1;
      end else if (start) begin
        if (cfg_m == 16'h0000) m_done <= 1'b1;
        else begin
          m_run <= 1'b1; m_j <= 0; m_M <= int'(cfg_m);
          m_w <= cfg_w; m_i <= cfg_i; m_o <= cfg_o;
        end
      end
    end
  end

  // Activity log used by the directed checks.
  int cnt_busy = 0, cnt_done = 0, cnt_ovl = 0, cnt_flush = 0;
  logic [15:0] wq[$], iq[$], oq[$];

  int c;
  logic [1:0] e_state;
  logic e_busy, e_wen, e_ien, e_sen, e_oen;
  logic [15:0] e_waddr, e_iaddr, e_oaddr;

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    e_state = 2'd0; e_busy = 1'b0; e_wen = 1'b0; e_ien = 1'b0; e_sen = 1'b0; e_oen = 1'b0;
    e_waddr = 16'h0000; e_iaddr = 16'h0000; e_oaddr = 16'h0000;
    if (m_run) begin
      e_busy = 1'b1;
      if (m_j < ROWS) begin
        e_state = 2'd1; e_wen = 1'b1; e_waddr = m_w + 16'(m_j);
      end else begin
        c = m_j - ROWS;
        e_state = (c < m_M) ? 2'd2 : 2'd3;
        e_sen = 1'b1;
        if (c < m_M) begin e_ien = 1'b1; e_iaddr = m_i + 16'(c); end
        if (c >= LAT) begin e_oen = 1'b1; e_oaddr = m_o + 16'(c - LAT); end
      end
    end
    chk("state", 32'(state), 32'(e_state));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(m_done));
    if (!(abort && m_run)) begin
      chk("weight_rd_en", 32'(weight_rd_en), 32'(e_wen));
      chk("preload_en", 32'(preload_en), 32'(e_wen));
      chk("weight_rd_addr", 32'(weight_rd_addr), 32'(e_waddr));
      chk("input_rd_en", 32'(input_rd_en), 32'(e_ien));
      chk("input_rd_addr", 32'(input_rd_addr), 32'(e_iaddr));
      chk("stream_en", 32'(stream_en), 32'(e_sen));
      chk("output_wr_en", 32'(output_wr_en), 32'(e_oen));
      chk("output_wr_addr", 32'(output_wr_addr), 32'(e_oaddr));
    end
    if (busy) cnt_busy <= cnt_busy + 1;
    if (done) cnt_done <= cnt_done + 1;
    if (input_rd_en && output_wr_en) cnt_ovl <= cnt_ovl + 1;
    if (state == 2'd3) cnt_flush <= cnt_flush + 1;
    if (weight_rd_en) wq.push_back(weight_rd_addr);
    if (input_rd_en) iq.push_back(input_rd_addr);
    if (output_wr_en) oq.push_back(output_wr_addr);
  end

  int b_busy, b_done, b_ovl, b_flush, b_w, b_i, b_o;

  task automatic snap();
    b_busy = cnt_busy; b_done = cnt_done; b_ovl = cnt_ovl; b_flush = cnt_flush;
    b_w = wq.size(); b_i = iq.size(); b_o = oq.size();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [15:0] m, input logic [15:0] w, input logic [15:0] i,
                          input logic [15:0] o);
    cfg_m = m; cfg_w = w; cfg_i = i; cfg_o = o;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    chk("done_within_budget", 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_w = 16'h0000; cfg_i = 16'h0000; cfg_o = 16'h0000; cfg_m = 16'h0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic run, M=3
    snap();
    do_start(16'd3, 16'h0010, 16'h0020, 16'h0030);
    wait_done(60);
    chk("m3_busy_cycles", 32'(cnt_busy - b_busy), 32'd14);
    chk("m3_done_pulses", 32'(cnt_done - b_done), 32'd1);
    chk("m3_wreads", 32'(wq.size() - b_w), 32'd4);
    chk("m3_wread0", 32'(wq[b_w]), 32'h10);
    chk("m3_wread3", 32'(wq[b_w + 3]), 32'h13);
    chk("m3_ireads", 32'(iq.size() - b_i), 32'd3);
    chk("m3_iread2", 32'(iq[b_i + 2]), 32'h22);
    chk("m3_writes", 32'(oq.size() - b_o), 32'd3);
    chk("m3_write0", 32'(oq[b_o]), 32'h30);
    chk("m3_write2", 32'(oq[b_o + 2]), 32'h32);

    // M=10: reads overlap writes for c=7..9, flush is 7 cycles
    snap();
    do_start(16'd10, 16'h0000, 16'h0100, 16'h0200);
    wait_done(80);
    chk("m10_busy_cycles", 32'(cnt_busy - b_busy), 32'd21);
    chk("m10_ireads", 32'(iq.size() - b_i), 32'd10);
    chk("m10_writes", 32'(oq.size() - b_o), 32'd10);
    chk("m10_write9", 32'(oq[b_o + 9]), 32'h209);
    chk("m10_overlap", 32'(cnt_ovl - b_ovl), 32'd3);
    chk("m10_flush", 32'(cnt_flush - b_flush), 32'd7);

    // Output address wrap
    snap();
    do_start(16'd2, 16'h0000, 16'h0000, 16'hFFFF);
    wait_done(60);
    chk("wrap_writes", 32'(oq.size() - b_o), 32'd2);
    chk("wrap_write0", 32'(oq[b_o]), 32'hFFFF);
    chk("wrap_write1", 32'(oq[b_o + 1]), 32'h0000);

    // start while busy with changed config is ignored
    snap();
    do_start(16'd3, 16'h0010, 16'h0020, 16'h0030);
    repeat (5) tick();
    cfg_m = 16'd5; cfg_i = 16'h0800; cfg_o = 16'h0900;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60);
    repeat (3) tick();
    chk("busy_start_busy_cycles", 32'(cnt_busy - b_busy), 32'd14);
    chk("busy_start_done", 32'(cnt_done - b_done), 32'd1);
    chk("busy_start_writes", 32'(oq.size() - b_o), 32'd3);
    chk("busy_start_write0", 32'(oq[b_o]), 32'h30);

    // abort at c=1 of STREAM
    cfg_m = 16'd3; cfg_i = 16'h0020; cfg_o = 16'h0030;
    snap();
    do_start(16'd3, 16'h0010, 16'h0020, 16'h0030);
    repeat (5) tick();
    chk("pre_abort_state", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("abort_no_done", 32'(cnt_done - b_done), 32'd0);
    chk("abort_no_writes", 32'(oq.size() - b_o), 32'd0);
    snap();
    do_start(16'd3, 16'h0010, 16'h0020, 16'h0030);
    wait_done(60);
    chk("after_abort_writes", 32'(oq.size() - b_o), 32'd3);
    chk("after_abort_done", 32'(cnt_done - b_done), 32'd1);

    // reset during FLUSH, then zero-length run
    snap();
    do_start(16'd3, 16'h0010, 16'h0020, 16'h0030);
    repeat (9) tick();
    chk("pre_reset_state", 32'(state), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stream_en", 32'(stream_en), 32'd0);
    chk("rst_wr_en", 32'(output_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(output_wr_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", 32'(cnt_done - b_done), 32'd0);
    snap();
    cfg_m = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("m0_done", 32'(done), 32'd1);
    chk("m0_busy", 32'(busy), 32'd0);
    tick();
    chk("m0_done_clear", 32'(done), 32'd0);
    repeat (3) tick();
    chk("m0_busy_cycles", 32'(cnt_busy - b_busy), 32'd0);
    chk("m0_done_pulses", 32'(cnt_done - b_done), 32'd1);
    chk("m0_no_reads", 32'(wq.size() - b_w + iq.size() - b_i), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
